mdu_unit: RTL and testbench
===========================

// Module: mdu_unit
// PURPOSE
//  Parametrised multiply/divide unit with HI/LO result outputs for the execute stage of the superscalar core.
//  Supports MULT/MULTU, DIV/DIVU, MADD/MADDU/MSUB/MSUBU and MUL (GPR result = low half).
//  Runs one operation at a time: pipelined multiplier, iterative divider, one extra cycle for accumulate.
//  The FU drives requests; the result is held until the pipeline acknowledges it.
// PARAMETERS
//  WIDTH       32  operand width; HI and LO are each WIDTH bits
//  MUL_STAGES  2   multiplier pipeline register stages (>=1)
//  DIV_STEP    1   quotient bits per divider cycle (1 or 2; WIDTH % DIV_STEP == 0)
// PORTS
//  clk        in   1       single clock, rising edge
//  resetn     in   1       asynchronous, active-low reset
//  flush      in   1       squash the in-flight op (exception/mispredict)
//  req_valid  in   1       request present
//  req_ready  out  1       unit can accept a request this cycle
//  req_op     in   mdu_op_t  operation code
//  req_a      in   WIDTH   rs operand
//  req_b      in   WIDTH   rt operand
//  req_hi     in   WIDTH   current HI (used only by accumulate ops)
//  req_lo     in   WIDTH   current LO (used only by accumulate ops)
//  resp_valid out  1       result valid; held until acknowledged
//  resp_ack   in   1       consumer takes the result
//  resp_hi    out  WIDTH   HI result
//  resp_lo    out  WIDTH   LO result (MUL: GPR value)
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  - Reset (resetn=0, async): state=IDLE; resp_valid=0; resp_hi=resp_lo=0; busy=0; pipeline valids cleared.
//  - req_ready = (state==IDLE) & ~flush. Accept occurs when req_valid & req_ready; operands latch on that edge.
//  - State machine:
//    IDLE -> MUL (mult-class op accepted) or DIV (div-class op accepted).
//    MUL  -> MUL_STAGES cycles -> ACC (MADD*/MSUB*) or DONE.
//    ACC  -> {HI,LO} +/- 2W-bit product, one cycle -> DONE.
//    DIV  -> WIDTH/DIV_STEP iterations, then one sign-fix cycle -> DONE.
//    DONE -> resp_valid=1; IDLE on resp_ack.
//  - Latency from accept to resp_valid:
//    MULT/MULTU/MUL = MUL_STAGES+1; accumulate ops = MUL_STAGES+2; DIV/DIVU = WIDTH/DIV_STEP+2.
//  - Multiply: operands are extended to WIDTH+1 bits (sign-extended for signed ops, zero-extended for unsigned);
//    the product is truncated to 2*WIDTH. Accumulate wraps modulo 2^(2*WIDTH); no overflow flag.
//  - Divide: restoring division on magnitudes. Signed: quotient is negated if the operand signs differ;
//    remainder takes the sign of the dividend. LO=quotient, HI=remainder.
//  - Divide by zero: LO = all ones, HI = dividend (both signed and unsigned); full latency still applies.
//  - Signed MIN / -1: LO = MIN, HI = 0 (wraps, no trap).
//  - flush: in any state, the next edge goes to IDLE and resp_valid=0; no request is accepted while flush=1.
//    flush takes priority over a simultaneous resp_ack or req_valid.
//  - resp_hi/resp_lo are stable while resp_valid=1. Request inputs are ignored outside of accept.
//  - A new request is accepted no earlier than the cycle after the IDLE return (no ack-through).
// STRUCTURE
//  - Shared package (mips.svh): mdu_op_t enum {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MADD, MDU_MADDU,
//    MDU_MSUB, MDU_MSUBU, MDU_MUL}; helper predicates is_signed_mdu() and is_acc_mdu().
//  - Sub-module mdu_div_iter: iterative restoring divider (start/done handshake, parameters WIDTH and DIV_STEP).
//  - The multiplier pipeline and the FSM stay in mdu_unit.
// TESTING (WIDTH=32, MUL_STAGES=2, DIV_STEP=1)
//  1. MULT a=0xFFFFFFFF(-1), b=2 -> after 3 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same operands -> HI=1, LO=0xFFFFFFFE.
//  2. MADDU HI=0, LO=0xFFFFFFFF, a=1, b=1 -> after 4 cycles HI=1, LO=0; MSUB HI=LO=0, a=1, b=1 -> HI=LO=0xFFFFFFFF.
//  3. DIV a=-7, b=2 -> after 34 cycles LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1); DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
//  4. DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
//  5. flush at cycle 10 of a DIV -> next cycle busy=0, resp_valid never rises; next MULT 3*4 -> LO=12, HI=0.
//  6. Hold resp_ack=0 for 5 cycles after DONE -> resp_valid and data stable, req_ready=0;
//     assert resetn=0 mid-MUL -> outputs zero immediately (async).

Source files
------------

// File: rtl/mdu_unit_pkg.sv
// Shared types for the multiply/divide unit: op codes, FSM states and op-class predicates.
package mdu_unit_pkg;

  typedef enum logic [3:0] {
    MDU_MULT,
    MDU_MULTU,
    MDU_DIV,
    MDU_DIVU,
    MDU_MADD,
    MDU_MADDU,
    MDU_MSUB,
    MDU_MSUBU,
    MDU_MUL
  } mdu_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_ACC,
    S_DIV,
    S_DONE
  } mdu_state_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_ITER,
    D_FIX
  } div_state_e;

  function automatic logic is_signed_mdu(input mdu_op_t op);
    return op inside {MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB, MDU_MUL};
  endfunction

  function automatic logic is_acc_mdu(input mdu_op_t op);
    return op inside {MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
  endfunction

  function automatic logic is_sub_mdu(input mdu_op_t op);
    return op inside {MDU_MSUB, MDU_MSUBU};
  endfunction

  function automatic logic is_div_mdu(input mdu_op_t op);
    return op inside {MDU_DIV, MDU_DIVU};
  endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// Request/response bundle between the execute-stage FU (master) and the MDU (slave).
interface mdu_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  import mdu_unit_pkg::*;

  logic             flush;
  logic             req_valid;
  logic             req_ready;
  mdu_op_t          req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [WIDTH-1:0] req_hi;
  logic [WIDTH-1:0] req_lo;
  logic             resp_valid;
  logic             resp_ack;
  logic [WIDTH-1:0] resp_hi;
  logic [WIDTH-1:0] resp_lo;
  logic             busy;

  modport master (
    output flush, req_valid, req_op, req_a, req_b, req_hi, req_lo, resp_ack,
    input  req_ready, resp_valid, resp_hi, resp_lo, busy
  );

  modport slave (
    input  flush, req_valid, req_op, req_a, req_b, req_hi, req_lo, resp_ack,
    output req_ready, resp_valid, resp_hi, resp_lo, busy
  );

endinterface

// File: rtl/mdu_div_iter.sv
// Iterative restoring divider on operand magnitudes, DIV_STEP quotient bits per cycle,
// followed by one sign-fix cycle during which done is high and the results are valid.
module mdu_div_iter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DIV_STEP = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             abort,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  import mdu_unit_pkg::*;

  localparam int unsigned ITERS = WIDTH / DIV_STEP;
  localparam int unsigned CNT_W = $clog2(ITERS + 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             div0_q, div0_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r, q;
  logic             a_neg, b_neg;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    dividend_d = dividend_q;
    cnt_d      = cnt_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    div0_d     = div0_q;
    trial      = '0;
    r          = rem_q;
    q          = quo_q;
    a_neg      = is_signed & dividend[WIDTH-1];
    b_neg      = is_signed & divisor[WIDTH-1];

    unique case (state_q)
      D_IDLE: begin
        if (start) begin
          quo_d      = a_neg ? -dividend : dividend;
          dvs_d      = b_neg ? -divisor : divisor;
          rem_d      = '0;
          qneg_d     = a_neg ^ b_neg;
          rneg_d     = a_neg;
          div0_d     = (divisor == '0);
          dividend_d = dividend;
          cnt_d      = '0;
          state_d    = D_ITER;
        end
      end
      D_ITER: begin
        // quo_q shifts dividend bits out at the top while quotient bits enter at the bottom
        for (int unsigned i = 0; i < DIV_STEP; i++) begin
          trial = {r, q[WIDTH-1]};
          if (trial >= {1'b0, dvs_q}) begin
            trial = trial - {1'b0, dvs_q};
            q     = {q[WIDTH-2:0], 1'b1};
          end else begin
            q     = {q[WIDTH-2:0], 1'b0};
          end
          r = trial[WIDTH-1:0];
        end
        rem_d = r;
        quo_d = q;
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = D_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      D_FIX:   state_d = D_IDLE;
      default: state_d = D_IDLE;
    endcase

    if (abort) begin
      state_d = D_IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= D_IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      dividend_q <= '0;
      cnt_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      div0_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      dividend_q <= dividend_d;
      cnt_q      <= cnt_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      div0_q     <= div0_d;
    end
  end

  assign done      = (state_q == D_FIX);
  assign quotient  = div0_q ? '1 : (qneg_q ? -quo_q : quo_q);
  assign remainder = div0_q ? dividend_q : (rneg_q ? -rem_q : rem_q);

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit: pipelined multiplier, accumulate cycle and iterative divider under one FSM,
// with the result held on the response bus until acknowledged.
module mdu_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned DIV_STEP   = 1
) (
  input  logic       clk,
  input  logic       resetn,
  mdu_unit_if.slave  bus
);
  import mdu_unit_pkg::*;

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

  mdu_state_e       state_q, state_d;
  mdu_op_t          op_q, op_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic             busy_q, busy_d;
  logic [PW-1:0]    pipe_q [MUL_STAGES];
  logic [PW-1:0]    pipe_d [MUL_STAGES];

  logic             accept;
  logic             req_signed;
  logic [PW-1:0]    a_ext, b_ext, product;
  logic             div_start, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign bus.req_ready  = (state_q == S_IDLE) & ~bus.flush;
  assign accept         = bus.req_valid & bus.req_ready;
  assign req_signed     = is_signed_mdu(bus.req_op);
  assign div_start      = accept & is_div_mdu(bus.req_op);

  // The first multiplier stage registers the product at the accept edge, so the request
  // operands never need holding; the W+1-bit extension folds into the 2W-bit extension.
  always_comb begin
    a_ext   = {{WIDTH{req_signed & bus.req_a[WIDTH-1]}}, bus.req_a};
    b_ext   = {{WIDTH{req_signed & bus.req_b[WIDTH-1]}}, bus.req_b};
    product = a_ext * b_ext;
    for (int unsigned i = 0; i < MUL_STAGES; i++) begin
      pipe_d[i] = (i == 0) ? (accept ? product : pipe_q[0]) : pipe_q[i-1];
    end
  end

  mdu_div_iter #(
    .WIDTH    (WIDTH),
    .DIV_STEP (DIV_STEP)
  ) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .abort     (bus.flush),
    .start     (div_start),
    .is_signed (req_signed),
    .dividend  (bus.req_a),
    .divisor   (bus.req_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = bus.req_op;
          acc_d   = {bus.req_hi, bus.req_lo};
          cnt_d   = '0;
          state_d = is_div_mdu(bus.req_op) ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        if (cnt_q == CNT_W'(MUL_STAGES - 1)) begin
          res_d   = pipe_q[MUL_STAGES-1];
          state_d = is_acc_mdu(op_q) ? S_ACC : S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACC: begin
        res_d   = is_sub_mdu(op_q) ? (acc_q - res_q) : (acc_q + res_q);
        state_d = S_DONE;
      end
      S_DIV: begin
        if (div_done) begin
          res_d   = {div_rem, div_quo};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.resp_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.flush) begin
      state_d = S_IDLE;
    end

    resp_valid_d = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      op_q         <= MDU_MULT;
      acc_q        <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      for (int unsigned i = 0; i < MUL_STAGES; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      res_q        <= res_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      for (int unsigned i = 0; i < MUL_STAGES; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hi    = res_q[PW-1:WIDTH];
  assign bus.resp_lo    = res_q[WIDTH-1:0];
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit (WIDTH=32, MUL_STAGES=2, DIV_STEP=1).
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  typedef struct {
    string       name;
    mdu_op_t     op;
    logic [31:0] a, b, hi, lo;
    int          lat;
    logic [31:0] ehi, elo;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mdu_unit_if #(.WIDTH(32)) bus ();

  mdu_unit #(
    .WIDTH      (32),
    .MUL_STAGES (2),
    .DIV_STEP   (1)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic idle_inputs();
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = MDU_MULT;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_hi    = '0;
    bus.req_lo    = '0;
    bus.resp_ack  = 1'b0;
  endtask

  // Presents a request at a negedge; it is accepted at the following posedge.
  task automatic issue(input mdu_op_t op, input logic [31:0] a, b, hi, lo);
    @(negedge clk);
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_hi    = hi;
    bus.req_lo    = lo;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = 32'hDEADBEEF;
    bus.req_b     = 32'h13579BDF;
    bus.req_hi    = 32'hA5A5A5A5;
    bus.req_lo    = 32'h5A5A5A5A;
  endtask

  // Cycles from accept to the first cycle with resp_valid high; 0 if the bound expires.
  task automatic wait_resp(output int lat);
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic ack();
    bus.resp_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ack = 1'b0;
  endtask

  task automatic run_op(input vec_t v, output int lat, output logic [31:0] hi, lo);
    issue(v.op, v.a, v.b, v.hi, v.lo);
    wait_resp(lat);
    hi = bus.resp_hi;
    lo = bus.resp_lo;
    if (lat != 0) ack();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b busy=%b expected 0 0", bus.resp_valid, bus.busy);
    end
    checks++;
    if (bus.resp_hi !== 32'h0 || bus.resp_lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: hi=%h lo=%h expected 0 0", bus.resp_hi, bus.resp_lo);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", bus.req_ready);
    end
  endtask

  task automatic test_mult();
    vec_t v [3];
    int lat;
    logic [31:0] hi, lo;
    v[0] = '{"mult_m1x2", MDU_MULT, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 3, 32'hFFFFFFFF, 32'hFFFFFFFE};
    v[1] = '{"multu_ffx2", MDU_MULTU, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 3, 32'h00000001, 32'hFFFFFFFE};
    v[2] = '{"mul_m3x5", MDU_MUL, 32'hFFFFFFFD, 32'h5, 32'h0, 32'h0, 3, 32'hFFFFFFFF, 32'hFFFFFFF1};
    foreach (v[i]) begin
      run_op(v[i], lat, hi, lo);
      checks++;
      if (lat != v[i].lat) begin
        errors++;
        $display("FAIL %s_lat: got %0d expected %0d", v[i].name, lat, v[i].lat);
      end
      checks++;
      if (hi !== v[i].ehi || lo !== v[i].elo) begin
        errors++;
        $display("FAIL %s_data: got %h_%h expected %h_%h", v[i].name, hi, lo, v[i].ehi, v[i].elo);
      end
    end
  endtask

  task automatic test_acc();
    vec_t v [4];
    int lat;
    logic [31:0] hi, lo;
    v[0] = '{"maddu_carry", MDU_MADDU, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 4, 32'h00000001, 32'h00000000};
    v[1] = '{"msub_wrap", MDU_MSUB, 32'h1, 32'h1, 32'h0, 32'h0, 4, 32'hFFFFFFFF, 32'hFFFFFFFF};
    v[2] = '{"madd_neg", MDU_MADD, 32'hFFFFFFFE, 32'h3, 32'h0, 32'hA, 4, 32'h00000000, 32'h00000004};
    v[3] = '{"msubu_big", MDU_MSUBU, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 4, 32'hFFFFFFFE, 32'h00000002};
    foreach (v[i]) begin
      run_op(v[i], lat, hi, lo);
      checks++;
      if (lat != v[i].lat) begin
        errors++;
        $display("FAIL %s_lat: got %0d expected %0d", v[i].name, lat, v[i].lat);
      end
      checks++;
      if (hi !== v[i].ehi || lo !== v[i].elo) begin
        errors++;
        $display("FAIL %s_data: got %h_%h expected %h_%h", v[i].name, hi, lo, v[i].ehi, v[i].elo);
      end
    end
  endtask

  task automatic test_div();
    vec_t v [6];
    int lat;
    logic [31:0] hi, lo;
    v[0] = '{"div_m7_2", MDU_DIV, 32'hFFFFFFF9, 32'h2, 32'h0, 32'h0, 34, 32'hFFFFFFFF, 32'hFFFFFFFD};
    v[1] = '{"divu_7_0", MDU_DIVU, 32'h7, 32'h0, 32'h0, 32'h0, 34, 32'h00000007, 32'hFFFFFFFF};
    v[2] = '{"divu_100_7", MDU_DIVU, 32'd100, 32'd7, 32'h0, 32'h0, 34, 32'h00000002, 32'h0000000E};
    v[3] = '{"div_7_m2", MDU_DIV, 32'h7, 32'hFFFFFFFE, 32'h0, 32'h0, 34, 32'h00000001, 32'hFFFFFFFD};
    v[4] = '{"div_m7_0", MDU_DIV, 32'hFFFFFFF9, 32'h0, 32'h0, 32'h0, 34, 32'hFFFFFFF9, 32'hFFFFFFFF};
    v[5] = '{"div_min_m1", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 34, 32'h00000000, 32'h80000000};
    foreach (v[i]) begin
      run_op(v[i], lat, hi, lo);
      checks++;
      if (lat != v[i].lat) begin
        errors++;
        $display("FAIL %s_lat: got %0d expected %0d", v[i].name, lat, v[i].lat);
      end
      checks++;
      if (hi !== v[i].ehi || lo !== v[i].elo) begin
        errors++;
        $display("FAIL %s_data: got %h_%h expected %h_%h", v[i].name, hi, lo, v[i].ehi, v[i].elo);
      end
    end
  endtask

  task automatic test_flush();
    vec_t v;
    int lat;
    logic seen;
    logic [31:0] hi, lo;
    issue(MDU_DIV, 32'hFFFFFFF9, 32'h2, 32'h0, 32'h0);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_div_idle: busy=%b ready=%b expected 0 1", bus.busy, bus.req_ready);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_resp: resp_valid rose=%b expected 0", seen);
    end

    bus.flush     = 1'b1;
    bus.req_op    = MDU_MULT;
    bus.req_valid = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got %b expected 0", bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_blocks_accept: busy=%b expected 0", bus.busy);
    end

    v = '{"mult_3x4", MDU_MULT, 32'h3, 32'h4, 32'h0, 32'h0, 3, 32'h0, 32'hC};
    run_op(v, lat, hi, lo);
    checks++;
    if (lat != 3 || hi !== 32'h0 || lo !== 32'hC) begin
      errors++;
      $display("FAIL flush_then_mult: lat=%0d hi=%h lo=%h expected 3 0 c", lat, hi, lo);
    end

    issue(MDU_MULT, 32'h5, 32'h6, 32'h0, 32'h0);
    wait_resp(lat);
    bus.flush    = 1'b1;
    bus.resp_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.resp_ack = 1'b0;
    checks++;
    if (lat != 3 || bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_ack: lat=%0d valid=%b busy=%b expected 3 0 0", lat, bus.resp_valid, bus.busy);
    end
  endtask

  task automatic test_hold();
    int lat;
    issue(MDU_MULTU, 32'h00010001, 32'h00010001, 32'h0, 32'h0);
    wait_resp(lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL hold_lat: got %0d expected 3", lat);
    end
    bus.req_valid = 1'b1;
    bus.req_op    = MDU_DIVU;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_ctrl_%0d: valid=%b ready=%b expected 1 0", c, bus.resp_valid, bus.req_ready);
      end
      checks++;
      if (bus.resp_hi !== 32'h00000001 || bus.resp_lo !== 32'h00020001) begin
        errors++;
        $display("FAIL hold_data_%0d: got %h_%h expected 00000001_00020001", c, bus.resp_hi, bus.resp_lo);
      end
    end
    bus.req_valid = 1'b0;
    ack();
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: busy=%b valid=%b expected 0 0", bus.busy, bus.resp_valid);
    end
  endtask

  task automatic test_async_reset();
    issue(MDU_MULT, 32'h7, 32'h9, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_busy_before: got %b expected 1", bus.busy);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_ctrl: busy=%b valid=%b expected 0 0", bus.busy, bus.resp_valid);
    end
    checks++;
    if (bus.resp_hi !== 32'h0 || bus.resp_lo !== 32'h0) begin
      errors++;
      $display("FAIL areset_data: got %h_%h expected 0_0", bus.resp_hi, bus.resp_lo);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_stays_idle: valid=%b busy=%b expected 0 0", bus.resp_valid, bus.busy);
    end
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    test_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    test_mult();
    test_acc();
    test_div();
    test_flush();
    test_hold();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
